// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - shared register map, bit indices and tx state enum
// Purpose: constants and types shared by the memory-mapped UART transmitter.
// Contents: word offsets of the register window, STATUS/CTRL bit positions,
//           and the serialiser state encoding.
package uart_mmio_pkg;

    // Word offsets (Addr[3:2]) inside the 16-byte register window.
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    // STATUS bit positions.
    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    // CTRL bit positions. CLR_OVF is write-one-to-clear and reads as 0.
    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_CLR_OVF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular TX byte FIFO with pointers and occupancy count
// Purpose: buffers bytes written by the core until the serialiser pops them.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (flushes the FIFO)
//   push, din    enqueue din; ignored when full
//   pop, dout    dequeue; dout is the current head (valid when !empty)
//   full, empty  occupancy flags derived from the registered count
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Flags come from the registered count, so a push that meets a full FIFO
    // is refused even if a pop happens on the same edge.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_mmio_tx.sv
// rtl/uart_mmio_tx.sv - memory-mapped 8N1 UART transmitter on the core data bus
// Purpose: the core stores bytes to TXDATA; they are queued and sent as 8N1
//          frames on tx. STATUS and CTRL support polled or interrupt use.
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   Addr, WriteData   core data-memory address and store data
//   memwrite          store strobe, acts on the rising edge when sel=1
//   ReadData, sel     combinational read data and window hit (top muxes on sel)
//   tx                serial output, idle high, registered
//   irq               registered: IE & FIFO empty & serialiser idle
module uart_mmio_tx
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        memwrite,
    output logic [31:0] ReadData,
    output logic        sel,
    output logic        tx,
    output logic        irq
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        irq_q, irq_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        ovf_q, ovf_d;

    logic [1:0]  off;
    logic        wr;
    logic        fifo_push;
    logic        fifo_pop;
    logic        ctrl_wr;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        baud_last;
    logic        busy;
    logic        unused_bits;

    // Byte lanes and the low address bits are not part of the register map.
    assign unused_bits = ^{Addr[1:0], WriteData[31:8]};

    assign sel       = (Addr[31:4] == BASE_ADDR[31:4]);
    assign off       = Addr[3:2];
    assign wr        = memwrite & sel;
    assign fifo_push = wr & (off == OFF_TXDATA);
    assign ctrl_wr   = wr & (off == OFF_CTRL);
    assign busy      = (state_q != IDLE);
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (fifo_push),
        .din   (WriteData[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Zero-latency read mux so a single-cycle load completes this cycle.
    always_comb begin
        ReadData = '0;
        if (sel) begin
            case (off)
                OFF_STATUS: begin
                    ReadData[STAT_BUSY]  = busy;
                    ReadData[STAT_FULL]  = fifo_full;
                    ReadData[STAT_EMPTY] = fifo_empty;
                    ReadData[STAT_OVF]   = ovf_q;
                end
                OFF_CTRL: begin
                    ReadData[CTRL_EN] = en_q;
                    ReadData[CTRL_IE] = ie_q;
                end
                default: ReadData = '0;
            endcase
        end
    end

    always_comb begin
        en_d  = en_q;
        ie_d  = ie_q;
        ovf_d = ovf_q;
        if (fifo_push && fifo_full) begin
            ovf_d = 1'b1;
        end
        if (ctrl_wr) begin
            en_d = WriteData[CTRL_EN];
            ie_d = WriteData[CTRL_IE];
            if (WriteData[CTRL_CLR_OVF]) begin
                ovf_d = 1'b0;
            end
        end
    end

    // Serialiser: every state change restarts the baud counter at 0.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (en_q && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit to keep frames contiguous.
                    if (en_q && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is computed from next-state values so the line flop changes on the
    // same edge as the state it represents.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign irq_d = ie_q & fifo_empty & (state_q == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b0;
            en_q    <= 1'b1;
            ie_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            irq_q   <= irq_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx  = tx_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_uart_mmio_tx.sv
// tb/tb_uart_mmio_tx.sv - self-checking bench for uart_mmio_tx
module tb_uart_mmio_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam logic [31:0] A_TX   = 32'h0000_1000;
    localparam logic [31:0] A_STAT = 32'h0000_1004;
    localparam logic [31:0] A_CTRL = 32'h0000_1008;
    localparam logic [31:0] A_RSV  = 32'h0000_100C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Addr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        memwrite = 1'b0;
    logic [31:0] ReadData;
    logic        sel;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_err = 0;

    uart_mmio_tx #(
        .BASE_ADDR    (32'h0000_1000),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .WriteData (WriteData),
        .memwrite  (memwrite),
        .ReadData  (ReadData),
        .sel       (sel),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line receiver: samples mid-bit, checks the stop bit, logs frame starts.
    int         cyc = 0;
    bit         in_frame = 1'b0;
    int         fstart = 0;
    int         moff = 0;
    logic [7:0] msh = 8'h0;
    logic [7:0] rx_q[$];
    int         start_q[$];

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx === 1'b0) begin
                in_frame = 1'b1;
                fstart   = cyc;
                start_q.push_back(cyc);
            end
        end else begin
            moff = cyc - fstart;
            if ((moff % CPB) == CPB / 2 && moff / CPB >= 1 && moff / CPB <= 8)
                msh[moff / CPB - 1] = tx;
            if (moff == 9 * CPB + CPB / 2) begin
                check("stop_bit", tx, 1'b1);
                rx_q.push_back(msh);
            end
            if (moff == FRAME - 1) in_frame = 1'b0;
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr      = a;
        WriteData = d;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
        Addr      = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d    = ReadData;
        Addr = 32'h0;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] d;
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            bus_read(A_STAT, d);
            if (d[0] == 1'b0 && d[2] == 1'b1) break;
        end
        check("drain_in_budget", (k < budget), 1'b1);
    endtask

    task automatic compare_rx(input string tag, input logic [7:0] exp_q[$]);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({tag, "_byte"}, rx_q[i], exp_q[i]);
    endtask

    task automatic check_gaps(input string tag);
        for (int i = 1; i < start_q.size(); i++)
            check({tag, "_gap"}, start_q[i] - start_q[i-1], FRAME);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin
        logic [31:0] d;
        logic [7:0]  exp_q[$];
        logic [7:0]  b;
        int          n;
        int          clr;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_irq", irq, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        bus_read(A_STAT, d); check("rst_status", d, 32'h4);
        bus_read(A_CTRL, d); check("rst_ctrl", d, 32'h1);
        Addr = A_CTRL; #1; check("sel_hit", sel, 1'b1); Addr = 32'h0;

        // Single byte 0xA5, cycle-exact waveform
        rx_q.delete(); start_q.delete();
        bus_write(A_TX, 32'hA5);
        @(negedge clk);
        check("sb_pre_tx", tx, 1'b1);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            check("sb_tx", tx, frame_bit(8'hA5, i / CPB));
            bus_read(A_STAT, d);
            check("sb_busy", d[0], 1'b1);
        end
        @(negedge clk);
        check("sb_post_tx", tx, 1'b1);
        bus_read(A_STAT, d); check("sb_post_status", d, 32'h4);
        exp_q = '{8'hA5};
        compare_rx("sb", exp_q);

        // Overflow with EN=0, then drain back-to-back
        bus_write(A_CTRL, 32'h0);
        for (int i = 1; i <= 5; i++) bus_write(A_TX, i);
        @(negedge clk);
        bus_read(A_STAT, d); check("ovf_status", d, 32'hA);
        rx_q.delete(); start_q.delete();
        bus_write(A_CTRL, 32'h1);
        wait_idle(400);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        compare_rx("ovf", exp_q);
        check("ovf_frames", start_q.size(), 4);
        check_gaps("ovf");
        bus_read(A_STAT, d); check("ovf_sticky", d, 32'hC);
        bus_write(A_CTRL, 32'h5);
        @(negedge clk);
        bus_read(A_STAT, d); check("ovf_cleared", d, 32'h4);

        // Decode isolation
        rx_q.delete();
        bus_write(32'h0000_2000, 32'h55);
        bus_write(A_RSV, 32'h66);
        bus_write(32'h0000_2008, 32'h0);
        @(negedge clk);
        bus_read(A_STAT, d); check("dec_status", d, 32'h4);
        bus_read(A_CTRL, d); check("dec_ctrl", d, 32'h1);
        Addr = 32'h0000_2000; #1;
        check("dec_sel", sel, 1'b0);
        check("dec_rdata", ReadData, 32'h0);
        Addr = 32'h0;
        bus_read(A_RSV, d); check("dec_rsv_read", d, 32'h0);
        bus_read(A_TX, d); check("dec_txdata_read", d, 32'h0);
        repeat (20) @(negedge clk);
        check("dec_no_frames", rx_q.size(), 0);

        // EN cleared during data bit 3
        rx_q.delete(); start_q.delete();
        bus_write(A_TX, 32'h3C);
        bus_write(A_TX, 32'hC3);
        repeat (16) @(negedge clk);
        bus_write(A_CTRL, 32'h0);
        repeat (60) @(negedge clk);
        exp_q = '{8'h3C};
        compare_rx("enoff", exp_q);
        bus_read(A_STAT, d); check("enoff_status", d, 32'h0);
        bus_write(A_CTRL, 32'h1);
        wait_idle(200);
        exp_q = '{8'h3C, 8'hC3};
        compare_rx("enon", exp_q);

        // irq timing
        bus_write(A_CTRL, 32'h3);
        repeat (2) @(negedge clk);
        check("irq_idle", irq, 1'b1);
        bus_write(A_TX, 32'h81);
        @(negedge clk);
        @(negedge clk);
        check("irq_drop", irq, 1'b0);
        repeat (40) @(negedge clk);
        check("irq_last_stop", irq, 1'b0);
        @(negedge clk);
        check("irq_rise", irq, 1'b1);
        bus_write(A_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        check("irq_ie_off", irq, 1'b0);

        // Randomized bursts against a queue model of the FIFO
        for (int r = 0; r < 6; r++) begin
            bus_write(A_CTRL, 32'h0);
            n = $urandom_range(1, 6);
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                bus_write(A_TX, {24'h0, b});
                if (exp_q.size() < 4) exp_q.push_back(b);
            end
            @(negedge clk);
            bus_read(A_STAT, d);
            check("rnd_status", d, ((n >= 4) ? 32'h2 : 32'h0) | ((n > 4) ? 32'h8 : 32'h0));
            clr = $urandom_range(0, 1);
            rx_q.delete(); start_q.delete();
            bus_write(A_CTRL, (clr != 0) ? 32'h5 : 32'h1);
            wait_idle(400);
            compare_rx("rnd", exp_q);
            check_gaps("rnd");
            bus_read(A_STAT, d);
            check("rnd_end_status", d, 32'h4 | ((n > 4 && clr == 0) ? 32'h8 : 32'h0));
            bus_write(A_CTRL, 32'h5);
        end

        // Reset mid-frame
        bus_write(A_CTRL, 32'h3);
        bus_write(A_TX, 32'h00);
        bus_write(A_TX, 32'h11);
        bus_write(A_TX, 32'h22);
        rx_q.delete();
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid_tx", tx, 1'b1);
        check("rstmid_irq", irq, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_read(A_STAT, d); check("rstmid_status", d, 32'h4);
        bus_read(A_CTRL, d); check("rstmid_ctrl", d, 32'h1);
        repeat (100) @(negedge clk);
        check("rstmid_no_frames", rx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_mmio_tx.md
Name: uart_mmio_tx

Overview:
Memory-mapped UART transmitter that responds to the single-cycle core's data-memory bus (Addr, WriteData, memwrite, ReadData). The core writes bytes into a small TX FIFO, and the block serialises them as 8N1 frames on a tx pin. It also exposes status and control registers for polled or interrupt-driven use. It sits beside data memory; the top level muxes ReadData using the sel output.

Parameters:
BASE_ADDR, 32'h0000_1000, base of the 16-byte register window (bits [3:0] must be 0)
CLKS_PER_BIT, 16, clock cycles per serial bit (minimum 2)
FIFO_DEPTH, 4, TX FIFO entries (power of two, minimum 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Addr  input  32  byte address from the core ALU
WriteData  input  32  store data from the core
memwrite  input  1  store strobe, sampled on the rising edge of clk
ReadData  output  32  combinational read data; 0 when sel=0
sel  output  1  combinational; 1 when Addr[31:4]==BASE_ADDR[31:4]
tx  output  1  serial line, idle high
irq  output  1  registered; 1 when the FIFO is empty, the shifter is idle and IE=1

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low. Asserting reset low immediately forces:
  - tx=1, irq=0, state=IDLE
  - FIFO empty, overflow=0, EN=1, IE=0
  - baud and bit counters to 0
- Decode: the word offset is Addr[3:2]; Addr[1:0] is ignored.
  - 0x0 TXDATA: a write pushes WriteData[7:0]; reads return 0.
  - 0x4 STATUS (read-only): bit0 busy (state!=IDLE), bit1 full, bit2 empty, bit3 overflow (sticky); all other bits 0.
  - 0x8 CTRL: bit0 EN, bit1 IE. Writing 1 to bit2 clears overflow; bit2 reads 0.
  - 0xC: reserved; reads 0, writes ignored.
- Writes take effect on the clk edge where memwrite=1 and sel=1. Writes with sel=0 are ignored entirely.
- Reads are purely combinational, with zero latency, so the core's single-cycle load completes in the same cycle.
- TXDATA push while full: the byte is dropped and overflow is set. "Full" is evaluated before any same-cycle pop, so a simultaneous pop does not rescue the push.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if EN=1 and the FIFO is non-empty, pop the head into the shift register at this edge and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. The bit counter runs 0..7; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle, if EN=1 and the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- tx is registered from the state and shift register; there are no combinational glitches.
- Latency: a push at edge N into an empty FIFO with the FSM in IDLE gives tx=0 starting after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Baud counter: counts 0..CLKS_PER_BIT-1, resets to 0 on every state change, and wraps.
- EN cleared mid-frame: the current frame completes and no further pops occur. FIFO contents are retained, and transmission resumes when EN=1.
- Reset mid-frame: tx returns to 1 immediately, the frame is aborted and the FIFO is flushed.
- FIFO: circular buffer with read/write pointers and count. The pointers wrap modulo FIFO_DEPTH, and count ranges 0..FIFO_DEPTH. A push and a pop in the same cycle (not full) leave count unchanged.
- irq: registered, equal to IE & empty & (state==IDLE), updated every cycle.

Decomposition:
- Shared package uart_mmio_pkg holds:
  - register offsets: OFF_TXDATA, OFF_STATUS, OFF_CTRL
  - STATUS/CTRL bit indices
  - the tx state enum (IDLE, START, DATA, STOP)
- One sub-module, uart_tx_fifo. Parameters WIDTH=8 and DEPTH. Ports: push, din, pop, dout, full, empty; async active-low reset.

Test Plan:
- Reset: with reset=0 mid-operation, check tx=1, irq=0, and that STATUS reads 0x4 after release; a CTRL read returns 0x1.
- Single byte: with CLKS_PER_BIT=4, write 0xA5 to 0x1000. Starting one cycle later, tx shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total). busy=1 throughout the frame, then 0.
- Overflow: with EN=0, write 5 bytes 0x01..0x05. STATUS=0xA (full, overflow). Set EN=1; exactly 0x01..0x04 go out back-to-back with no idle gap; 0x05 is never sent. Writing CTRL=0x5 clears overflow.
- Decode isolation: writes to 0x2000 and to 0x100C leave the FIFO empty; a read at 0x2000 gives sel=0 and ReadData=0.
- EN cleared mid-frame: clear EN during DATA bit 3 with 2 bytes queued. The current frame completes and the second byte stays queued (empty=0) until EN=1.
- irq: with IE=1, irq rises one cycle after the last STOP completes. Writing a byte drops irq on the next edge.
